// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared game-state codes, FSM encoding and segment constants for countdown_display
package bomb_pkg;

  localparam logic [7:0] GS_RUN   = 8'h10;
  localparam logic [7:0] GS_END_A = 8'h20;
  localparam logic [7:0] GS_END_B = 8'h30;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_EXPIRED = 2'd2,
    ST_FROZEN  = 2'd3
  } cd_state_t;

  function automatic logic is_terminal(input logic [7:0] gs);
    return (gs == GS_END_A) || (gs == GS_END_B);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - BCD digit to active-low {g,f,e,d,c,b,a} segments, non-BCD codes show "E"
module seg7_decode
  import bomb_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  // pure lookup; leading zeros are shown, never blanked
  always_comb begin
    seg = SEG_E;
    case (digit)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/countdown_display.sv
// rtl/countdown_display.sv - countdown FSM and registered 3-digit display, blinking under COUNTDOWN_BLINK_EN
module countdown_display
  import bomb_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BLINK_HZ  = 2,
  parameter int WARN_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] game_state,
  input  logic [3:0] value_three,
  input  logic [3:0] value_two,
  input  logic [3:0] value_one,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       warn,
  output logic       timeout
);

  localparam logic [9:0] WARN_LIMIT = 10'(WARN_SECS);

  cd_state_t  state, state_next;
  logic [3:0] lat_three, lat_two, lat_one;
  logic [3:0] src_three, src_two, src_one;
  logic [6:0] seg_three, seg_two, seg_one;
  logic [9:0] remaining;
  logic       zero, run, term, hold_latched, warn_next, blank_next;

  // decode the inputs: remaining seconds and the game-state class
  always_comb begin
    remaining = {6'd0, value_three} * 10'd100 + {6'd0, value_two} * 10'd10 + {6'd0, value_one};
    zero      = (value_three == 4'd0) && (value_two == 4'd0) && (value_one == 4'd0);
    run       = (game_state == GS_RUN);
    term      = is_terminal(game_state);
  end

  // next-state rules; a terminal code wins over a simultaneous 000 count
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (run && !zero) state_next = ST_ARMED;
      ST_ARMED:   if (term) state_next = ST_FROZEN;
                  else if (run) state_next = zero ? ST_EXPIRED : ST_ARMED;
                  else state_next = ST_IDLE;
      ST_EXPIRED: if (term) state_next = ST_FROZEN;
                  else if (!run) state_next = ST_IDLE;
      ST_FROZEN:  if (!term) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // choose live or frozen digits for the next display value
  always_comb begin
    hold_latched = (state == ST_FROZEN) && (state_next == ST_FROZEN);
    src_three    = hold_latched ? lat_three : value_three;
    src_two      = hold_latched ? lat_two   : value_two;
    src_one      = hold_latched ? lat_one   : value_one;
    warn_next    = (state_next == ST_ARMED) && (remaining < WARN_LIMIT);
  end

  seg7_decode u_dec_three (.digit(src_three), .seg(seg_three));
  seg7_decode u_dec_two   (.digit(src_two),   .seg(seg_two));
  seg7_decode u_dec_one   (.digit(src_one),   .seg(seg_one));

`ifdef COUNTDOWN_BLINK_EN
  localparam int HALF_RAW    = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF_PERIOD = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CNT_W       = (HALF_PERIOD < 2) ? 1 : $clog2(HALF_PERIOD);

  logic [CNT_W-1:0] blink_cnt;
  logic             phase, phase_next, arming, wrap;

  // phase seen by the display next cycle; restarts at 0 whenever the countdown arms
  always_comb begin
    arming     = (state == ST_IDLE) && (state_next == ST_ARMED);
    wrap       = (blink_cnt == CNT_W'(HALF_PERIOD - 1));
    phase_next = arming ? 1'b0 : (wrap ? ~phase : phase);
    blank_next = warn_next && !phase_next;
  end

  // free-running half-period prescaler, cleared on arming
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= (arming || wrap) ? '0 : blink_cnt + CNT_W'(1);
      phase     <= phase_next;
    end
  end
`else
  assign blank_next = 1'b0;
`endif

  // state register with registered display, warn and one-shot timeout
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      hex2      <= SEG_BLANK;
      hex1      <= SEG_BLANK;
      hex0      <= SEG_BLANK;
      warn      <= 1'b0;
      timeout   <= 1'b0;
      lat_three <= 4'd0;
      lat_two   <= 4'd0;
      lat_one   <= 4'd0;
    end else begin
      state   <= state_next;
      timeout <= (state == ST_ARMED) && (state_next == ST_EXPIRED);
      warn    <= warn_next;
      hex2    <= blank_next ? SEG_BLANK : seg_three;
      hex1    <= blank_next ? SEG_BLANK : seg_two;
      hex0    <= blank_next ? SEG_BLANK : seg_one;
      if ((state_next == ST_FROZEN) && (state != ST_FROZEN)) begin
        lat_three <= value_three;
        lat_two   <= value_two;
        lat_one   <= value_one;
      end
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// tb/tb_countdown_display.sv - self-checking bench for countdown_display (model plus directed literal checks)
module tb_countdown_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] game_state = 8'h00;
  logic [3:0] value_three = 4'd0, value_two = 4'd0, value_one = 4'd0;
  logic [6:0] hex2, hex1, hex0;
  logic       warn, timeout;

  int total = 0;
  int bad = 0;

`ifdef COUNTDOWN_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  countdown_display #(.CLK_HZ(8), .BLINK_HZ(2), .WARN_SECS(10)) dut (
    .clk(clk), .reset(reset), .game_state(game_state),
    .value_three(value_three), .value_two(value_two), .value_one(value_one),
    .hex2(hex2), .hex1(hex1), .hex0(hex0), .warn(warn), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // segment images written from the digit shapes
  logic [6:0] font [16];
  initial begin
    font[0] = 7'h40; font[1] = 7'h79; font[2] = 7'h24; font[3] = 7'h30;
    font[4] = 7'h19; font[5] = 7'h12; font[6] = 7'h02; font[7] = 7'h78;
    font[8] = 7'h00; font[9] = 7'h10;
    for (int i = 10; i < 16; i++) font[i] = 7'b0000110;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: mode 0 idle, 1 counting, 2 expired, 3 frozen
  int mode = 0;
  int since_arm = 0;
  int held [3];
  int m_hex2 = 7'h7F, m_hex1 = 7'h7F, m_hex0 = 7'h7F, m_warn = 0, m_to = 0;
  bit started = 0;

  always @(posedge clk) begin
    int secs, nxt, d3, d2, d1;
    bit zero, run, term;
    if (!reset) begin
      mode = 0; since_arm = 0; m_to = 0; m_warn = 0;
      m_hex2 = 7'h7F; m_hex1 = 7'h7F; m_hex0 = 7'h7F;
    end else begin
      d3 = value_three; d2 = value_two; d1 = value_one;
      secs = (100 * d3 + 10 * d2 + d1) % 1024;
      zero = (secs == 0) && (d3 == 0) && (d2 == 0) && (d1 == 0);
      run  = (game_state == 8'h10);
      term = (game_state == 8'h20) || (game_state == 8'h30);
      nxt = mode;
      if (mode == 0) nxt = (run && !zero) ? 1 : 0;
      else if (mode == 3) nxt = term ? 3 : 0;
      else if (term) nxt = 3;
      else if (!run) nxt = 0;
      else if (mode == 1 && zero) nxt = 2;
      m_to = (mode == 1 && nxt == 2);
      if (nxt == 3 && mode != 3) begin held[0] = d3; held[1] = d2; held[2] = d1; end
      if (nxt == 3) begin d3 = held[0]; d2 = held[1]; d1 = held[2]; end
      since_arm = (mode == 0 && nxt == 1) ? 0 : since_arm + 1;
      m_warn = (nxt == 1) && (secs < 10);
      if (BLINK && m_warn && ((since_arm / 2) % 2 == 0)) begin
        m_hex2 = 7'h7F; m_hex1 = 7'h7F; m_hex0 = 7'h7F;
      end else begin
        m_hex2 = font[d3]; m_hex1 = font[d2]; m_hex0 = font[d1];
      end
      mode = nxt;
    end
    started = 1;
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      check("model_hex2", hex2, m_hex2);
      check("model_hex1", hex1, m_hex1);
      check("model_hex0", hex0, m_hex0);
      check("model_warn", warn, m_warn);
      check("model_timeout", timeout, m_to);
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic drive(input logic [7:0] gs, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    game_state = gs; value_three = a; value_two = b; value_one = c;
  endtask

  initial begin
    int pulses, blanks, warns;
    cyc(2);
    check("reset_hex2", hex2, 7'h7F);
    check("reset_hex0", hex0, 7'h7F);
    check("reset_warn", warn, 0);
    check("reset_timeout", timeout, 0);

    reset = 1'b1;
    drive(8'h00, 4'hC, 4'hC, 4'hC);
    cyc(1);
    check("idle_E_hex1", hex1, 7'b0000110);

    drive(8'h10, 4'd1, 4'd2, 4'd0);
    cyc(1);
    check("arm_hex2", hex2, 7'b1111001);
    check("arm_hex1", hex1, 7'b0100100);
    check("arm_hex0", hex0, 7'b1000000);
    check("arm_warn", warn, 0);

    drive(8'h00, 4'd0, 4'd1, 4'd0);
    cyc(1);
    drive(8'h10, 4'd0, 4'd1, 4'd0);
    cyc(2);
    check("ten_no_warn", warn, 0);
    drive(8'h10, 4'd0, 4'd0, 4'd9);
    blanks = 0; warns = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      warns += warn;
      if (hex0 == 7'h7F) blanks++;
      else check("blink_009", hex0, 7'b0010000);
    end
    check("warn_cycles", warns, 8);
    check("blank_cycles", blanks, BLINK ? 4 : 0);

    drive(8'h10, 4'd0, 4'd0, 4'd1);
    cyc(1);
    drive(8'h10, 4'd0, 4'd0, 4'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      pulses += timeout;
      if (i > 0) check("expired_hex0", hex0, 7'b1000000);
    end
    check("timeout_pulses", pulses, 1);
    check("expired_warn", warn, 0);

    drive(8'h00, 4'd0, 4'd4, 4'd2);
    cyc(1);
    drive(8'h10, 4'd0, 4'd4, 4'd2);
    cyc(1);
    drive(8'h20, 4'd0, 4'd4, 4'd2);
    cyc(1);
    drive(8'h20, 4'd9, 4'd9, 4'd9);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      pulses += timeout;
    end
    check("frozen_hex2", hex2, 7'b1000000);
    check("frozen_hex1", hex1, 7'b0011001);
    check("frozen_hex0", hex0, 7'b0100100);
    check("frozen_timeout", pulses, 0);

    drive(8'h00, 4'd0, 4'd0, 4'd5);
    cyc(1);
    drive(8'h10, 4'd0, 4'd0, 4'd5);
    cyc(1);
    drive(8'h30, 4'd0, 4'd0, 4'd0);
    cyc(1);
    check("term_zero_timeout", timeout, 0);
    check("term_zero_hex0", hex0, 7'b1000000);

    drive(8'h00, 4'd0, 4'd0, 4'd1);
    cyc(1);
    drive(8'h10, 4'd0, 4'd0, 4'd1);
    cyc(1);
    drive(8'h10, 4'd0, 4'd0, 4'd0);
    reset = 1'b0;
    cyc(1);
    check("rst_mid_timeout", timeout, 0);
    check("rst_mid_hex1", hex1, 7'h7F);
    check("rst_mid_warn", warn, 0);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      pulses += timeout;
    end
    check("rst_no_pending", pulses, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
